// File: rtl/pgm_pkg.sv
// Shared definitions for the packet-generator read side: word-type codes,
// FSM state encoding and bus widths.
package pgm_pkg;

   localparam int WORD_W     = 134;
   localparam int RAM_DW     = 144;
   localparam int PHV_W      = 1024;
   localparam int RAM_AW_DEF = 7;

   localparam logic [1:0] WT_HEAD = 2'b01;
   localparam logic [1:0] WT_BODY = 2'b11;
   localparam logic [1:0] WT_TAIL = 2'b10;

   typedef enum logic [1:0] {
      IDLE_S   = 2'd0,
      BYPASS_S = 2'd1,
      RD_S     = 2'd2,
      GAP_S    = 2'd3
   } rd_state_e;

   function automatic logic [1:0] word_type(input logic [WORD_W-1:0] w);
      return w[WORD_W-1 -: 2];
   endfunction

endpackage

// File: rtl/pgm_rd_gap_cnt.sv
// Inter-packet gap timer: down-counter loaded with the gap length, done at zero.
module pgm_rd_gap_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/pgm_rd.sv
// Packet generator read side: bypass forwarding and template replay from PGM_RAM.
// Optional build macro PGM_RD_TIMESTAMP_EN stamps word 1 of generated packets.
//
// state    | meaning
// IDLE_S   | waiting for a bypass head or a (pending) start
// BYPASS_S | forwarding a pgm_wr packet word by word
// RD_S     | reading the template from RAM and emitting it
// GAP_S    | idle gap between generated packets
module pgm_rd
   import pgm_pkg::*;
#(
   parameter string      PLATFORM   = "Xilinx",
   parameter logic [7:0] LMID       = 8'd63,
   parameter int         GAP_CYCLES = 16,
   parameter int         RAM_AW     = RAM_AW_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [PHV_W-1:0]  in_rd_phv,
   input  logic              in_rd_phv_wr,
   output logic              out_rd_phv_alf,
   input  logic [WORD_W-1:0] in_rd_data,
   input  logic              in_rd_data_wr,
   input  logic              in_rd_valid,
   input  logic              in_rd_valid_wr,
   output logic              out_rd_alf,
   input  logic              pgm_bypass_flag,
   input  logic              pgm_sent_start_flag,
   input  logic              pgm_sent_finish_flag,
   output logic              rd2ram_rd_en,
   output logic [RAM_AW-1:0] rd2ram_addr,
   input  logic [RAM_DW-1:0] ram2rd_rdata,
   output logic [PHV_W-1:0]  out_rd_phv,
   output logic              out_rd_phv_wr,
   input  logic              in_rd_phv_alf,
   output logic [WORD_W-1:0] out_rd_data,
   output logic              out_rd_data_wr,
   output logic              out_rd_valid,
   output logic              out_rd_valid_wr,
   input  logic              in_rd_alf,
   output logic [31:0]       gen_pkt_cnt,
   output logic [15:0]       drop_word_cnt
);

   localparam logic [15:0] GAP_LD = 16'(GAP_CYCLES);

   rd_state_e         state;
   logic              armed;
   logic              start_d, finish_d, start_p, finish_p;
   logic              stop_req, start_pend;
   logic              rd_vld;
   logic [RAM_AW-1:0] addr_d;
   logic              gap_done;

   logic [WORD_W-1:0] ram_word, gen_word;
   logic              wrap_hit, tail_ev, in_head, in_tail;

   assign out_rd_phv_alf = in_rd_phv_alf;
   assign out_rd_alf     = in_rd_alf;

   assign ram_word = ram2rd_rdata[WORD_W-1:0];
   assign wrap_hit = (addr_d == {RAM_AW{1'b1}});
   assign tail_ev  = rd_vld && ((word_type(ram_word) == WT_TAIL) || wrap_hit);
   assign in_head  = in_rd_data_wr && (word_type(in_rd_data) == WT_HEAD);
   assign in_tail  = in_rd_data_wr && (word_type(in_rd_data) == WT_TAIL);

`ifdef PGM_RD_TIMESTAMP_EN
   logic [63:0] ts_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ts_cnt <= '0;
      else     ts_cnt <= ts_cnt + 64'd1;
   end
`endif

   always_comb begin
      gen_word = ram_word;
      if (wrap_hit) gen_word[WORD_W-1 -: 2] = WT_TAIL;
`ifdef PGM_RD_TIMESTAMP_EN
      if (addr_d == RAM_AW'(1)) gen_word[63:0] = ts_cnt;
`endif
   end

   pgm_rd_gap_cnt #(.CNT_W(16)) u_gap_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (tail_ev && (state == RD_S)),
      .en       (state == GAP_S),
      .load_val (GAP_LD),
      .done     (gap_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE_S;
         armed           <= 1'b0;
         start_d         <= 1'b0;
         finish_d        <= 1'b0;
         start_p         <= 1'b0;
         finish_p        <= 1'b0;
         stop_req        <= 1'b0;
         start_pend      <= 1'b0;
         rd_vld          <= 1'b0;
         addr_d          <= '0;
         rd2ram_rd_en    <= 1'b0;
         rd2ram_addr     <= '0;
         out_rd_phv      <= '0;
         out_rd_phv_wr   <= 1'b0;
         out_rd_data     <= '0;
         out_rd_data_wr  <= 1'b0;
         out_rd_valid    <= 1'b0;
         out_rd_valid_wr <= 1'b0;
         gen_pkt_cnt     <= '0;
         drop_word_cnt   <= '0;
      end else begin
         // A flag already high when reset releases is not a new edge.
         armed    <= 1'b1;
         start_d  <= pgm_sent_start_flag;
         finish_d <= pgm_sent_finish_flag;
         start_p  <= armed && pgm_sent_start_flag && !start_d;
         finish_p <= armed && pgm_sent_finish_flag && !finish_d;

         out_rd_phv_wr   <= 1'b0;
         out_rd_data_wr  <= 1'b0;
         out_rd_valid    <= 1'b0;
         out_rd_valid_wr <= 1'b0;
         rd_vld          <= rd2ram_rd_en;
         addr_d          <= rd2ram_addr;

         if (finish_p) stop_req <= 1'b1;

         if (((state == RD_S) || (state == GAP_S)) && in_rd_data_wr &&
             (drop_word_cnt != 16'hFFFF))
            drop_word_cnt <= drop_word_cnt + 16'd1;

         case (state)
            IDLE_S: begin
               if (!finish_p) stop_req <= 1'b0;
               if (in_head) begin
                  out_rd_data    <= in_rd_data;
                  out_rd_data_wr <= 1'b1;
                  out_rd_phv     <= in_rd_phv;
                  out_rd_phv_wr  <= in_rd_phv_wr;
                  out_rd_valid   <= in_rd_valid;
                  if (start_p) start_pend <= 1'b1;
                  state <= BYPASS_S;
               end else if ((start_p || start_pend) && !in_rd_alf) begin
                  rd2ram_rd_en <= 1'b1;
                  rd2ram_addr  <= '0;
                  start_pend   <= 1'b0;
                  state        <= RD_S;
               end else if (start_p) begin
                  start_pend <= 1'b1;
               end
            end

            BYPASS_S: begin
               out_rd_phv    <= in_rd_phv;
               out_rd_phv_wr <= in_rd_phv_wr;
               if (start_p) start_pend <= 1'b1;
               if (in_rd_data_wr) begin
                  out_rd_data    <= in_rd_data;
                  out_rd_data_wr <= 1'b1;
               end
               if (in_tail) begin
                  out_rd_valid    <= 1'b1;
                  out_rd_valid_wr <= 1'b1;
                  state           <= IDLE_S;
               end
            end

            RD_S: begin
               if (rd2ram_rd_en) rd2ram_addr <= rd2ram_addr + 1'b1;
               if (rd_vld) begin
                  out_rd_data    <= gen_word;
                  out_rd_data_wr <= 1'b1;
                  out_rd_phv     <= '0;
                  out_rd_phv_wr  <= (word_type(gen_word) == WT_HEAD);
               end
               // The read issued alongside the tail is discarded via rd_vld.
               if (tail_ev) begin
                  out_rd_valid    <= 1'b1;
                  out_rd_valid_wr <= 1'b1;
                  gen_pkt_cnt     <= gen_pkt_cnt + 32'd1;
                  rd_vld          <= 1'b0;
                  if (stop_req || finish_p) begin
                     rd2ram_rd_en <= 1'b0;
                     state        <= IDLE_S;
                  end else if ((GAP_CYCLES == 0) && !in_rd_alf) begin
                     rd2ram_rd_en <= 1'b1;
                     rd2ram_addr  <= '0;
                  end else begin
                     rd2ram_rd_en <= 1'b0;
                     state        <= GAP_S;
                  end
               end
            end

            GAP_S: begin
               if (stop_req || finish_p) begin
                  state <= IDLE_S;
               end else if (gap_done && !in_rd_alf) begin
                  rd2ram_rd_en <= 1'b1;
                  rd2ram_addr  <= '0;
                  state        <= RD_S;
               end
            end

            default: state <= IDLE_S;
         endcase
      end
   end

   logic unused_ok;
   assign unused_ok = &{1'b0, pgm_bypass_flag, in_rd_valid_wr,
                        ram2rd_rdata[RAM_DW-1:WORD_W], LMID,
                        (PLATFORM == "Xilinx")};

endmodule

// File: tb/tb_pgm_rd.sv
// Scoreboard bench for pgm_rd: bypass, generation, finish, backpressure,
// wrap guard and mid-packet reset.
module tb_pgm_rd;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1023:0] in_rd_phv = '0;
   logic          in_rd_phv_wr = 1'b0;
   logic          out_rd_phv_alf;
   logic [133:0]  in_rd_data = '0;
   logic          in_rd_data_wr = 1'b0;
   logic          in_rd_valid = 1'b0;
   logic          in_rd_valid_wr = 1'b0;
   logic          out_rd_alf;
   logic          pgm_bypass_flag = 1'b0;
   logic          pgm_sent_start_flag = 1'b0;
   logic          pgm_sent_finish_flag = 1'b0;
   logic          rd2ram_rd_en;
   logic [6:0]    rd2ram_addr;
   logic [143:0]  ram2rd_rdata = '0;
   logic [1023:0] out_rd_phv;
   logic          out_rd_phv_wr;
   logic          in_rd_phv_alf = 1'b0;
   logic [133:0]  out_rd_data;
   logic          out_rd_data_wr;
   logic          out_rd_valid;
   logic          out_rd_valid_wr;
   logic          in_rd_alf = 1'b0;
   logic [31:0]   gen_pkt_cnt;
   logic [15:0]   drop_word_cnt;

   pgm_rd dut (
      .clk                  (clk),
      .rst                  (rst),
      .in_rd_phv            (in_rd_phv),
      .in_rd_phv_wr         (in_rd_phv_wr),
      .out_rd_phv_alf       (out_rd_phv_alf),
      .in_rd_data           (in_rd_data),
      .in_rd_data_wr        (in_rd_data_wr),
      .in_rd_valid          (in_rd_valid),
      .in_rd_valid_wr       (in_rd_valid_wr),
      .out_rd_alf           (out_rd_alf),
      .pgm_bypass_flag      (pgm_bypass_flag),
      .pgm_sent_start_flag  (pgm_sent_start_flag),
      .pgm_sent_finish_flag (pgm_sent_finish_flag),
      .rd2ram_rd_en         (rd2ram_rd_en),
      .rd2ram_addr          (rd2ram_addr),
      .ram2rd_rdata         (ram2rd_rdata),
      .out_rd_phv           (out_rd_phv),
      .out_rd_phv_wr        (out_rd_phv_wr),
      .in_rd_phv_alf        (in_rd_phv_alf),
      .out_rd_data          (out_rd_data),
      .out_rd_data_wr       (out_rd_data_wr),
      .out_rd_valid         (out_rd_valid),
      .out_rd_valid_wr      (out_rd_valid_wr),
      .in_rd_alf            (in_rd_alf),
      .gen_pkt_cnt          (gen_pkt_cnt),
      .drop_word_cnt        (drop_word_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [143:0] mem [0:127];
   always @(posedge clk) if (rd2ram_rd_en) ram2rd_rdata <= mem[rd2ram_addr];

   typedef struct {
      logic [133:0]  d;
      logic [133:0]  m;
      logic          phv_wr;
      logic [1023:0] phv;
      logic          vwr;
      int            cyc;
   } exp_t;

   exp_t sb[$];
   int   vecs = 0;
   int   errs = 0;

   function automatic logic [133:0] mkw(input logic [1:0] t, input logic [3:0] tag, input int i);
      return {t, tag, 64'hDEAD_0000_0000_0000 | 64'(i), 64'h0123_4567_89AB_0000 | 64'(i)};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (out_rd_data_wr) begin
            vecs++;
            if (sb.size() == 0) begin
               errs++;
               $display("FAIL sb_unexpected: got word %h at cycle %0d, expected none", out_rd_data, cyc);
            end else begin
               e = sb.pop_front();
               if ((((out_rd_data ^ e.d) & e.m) !== '0) || (out_rd_phv_wr !== e.phv_wr) ||
                   (out_rd_valid_wr !== e.vwr) || (out_rd_valid !== e.vwr) ||
                   (e.phv_wr && (out_rd_phv !== e.phv)) || (cyc != e.cyc)) begin
                  errs++;
                  $display("FAIL sb_word: got d=%h phv_wr=%b vwr=%b cyc=%0d, expected d=%h phv_wr=%b vwr=%b cyc=%0d",
                           out_rd_data, out_rd_phv_wr, out_rd_valid_wr, cyc, e.d, e.phv_wr, e.vwr, e.cyc);
               end
            end
         end else if (out_rd_phv_wr || out_rd_valid_wr) begin
            vecs++;
            errs++;
            $display("FAIL stray_strobe: got phv_wr=%b valid_wr=%b without data_wr, expected 0 0",
                     out_rd_phv_wr, out_rd_valid_wr);
         end
      end
   endtask

   // One bypass word driven at a negedge; it should appear one edge later.
   task automatic drv_word(input logic [133:0] w, input logic [1023:0] phv);
      exp_t e;
      in_rd_data     = w;
      in_rd_data_wr  = 1'b1;
      in_rd_phv      = phv;
      in_rd_phv_wr   = (w[133:132] == 2'b01);
      in_rd_valid    = (w[133:132] == 2'b10);
      in_rd_valid_wr = (w[133:132] == 2'b10);
      e.d = w; e.m = '1; e.phv = phv; e.phv_wr = in_rd_phv_wr; e.vwr = in_rd_valid_wr;
      e.cyc = cyc + 1;
      sb.push_back(e);
      @(negedge clk);
      in_rd_data_wr = 1'b0; in_rd_phv_wr = 1'b0; in_rd_valid = 1'b0; in_rd_valid_wr = 1'b0;
   endtask

   task automatic push_gen(input int n, input int c0);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.d = mem[i][133:0];
         if (i == 127) e.d[133:132] = 2'b10;
         e.m = '1;
`ifdef PGM_RD_TIMESTAMP_EN
         if (i == 1) e.m[63:0] = '0;
`endif
         e.phv_wr = (e.d[133:132] == 2'b01);
         e.phv    = '0;
         e.vwr    = (e.d[133:132] == 2'b10);
         e.cyc    = c0 + i;
         sb.push_back(e);
      end
   endtask

   task automatic load_tmpl();
      mem[0] = {10'h2A5, mkw(2'b01, 4'h1, 0)};
      mem[1] = {10'h2A5, mkw(2'b11, 4'h1, 1)};
      mem[2] = {10'h2A5, mkw(2'b11, 4'h1, 2)};
      mem[3] = {10'h2A5, mkw(2'b10, 4'h1, 3)};
   endtask

   task automatic wait_rd1(input int lim, input string nm);
      int n = 0;
      while (!(rd2ram_rd_en && (rd2ram_addr == 7'd1)) && (n < lim)) begin
         @(negedge clk); n++;
      end
      if (n >= lim) begin
         vecs++; errs++;
         $display("FAIL %s: timeout, got no read at addr 1, expected one within %0d cycles", nm, lim);
      end
   endtask

   task automatic wait_gen(input logic [31:0] cnt, input int lim, input string nm);
      int n = 0;
      while ((gen_pkt_cnt != cnt) && (n < lim)) begin
         @(negedge clk); n++;
      end
      if (n >= lim) begin
         vecs++; errs++;
         $display("FAIL %s: timeout, got gen_pkt_cnt %0d, expected %0d", nm, gen_pkt_cnt, cnt);
      end
   endtask

   task automatic no_rd(input int n, input string nm);
      logic seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (rd2ram_rd_en) seen = 1'b1;
      end
      chk(nm, 64'(seen), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      fork monitor(); join_none
      for (int i = 0; i < 128; i++) mem[i] = '0;
      load_tmpl();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      chk("rst_data_wr", 64'(out_rd_data_wr), 0);
      chk("rst_data", 64'(|out_rd_data), 0);
      chk("rst_rd_en", 64'(rd2ram_rd_en), 0);
      chk("rst_gen_cnt", 64'(gen_pkt_cnt), 0);

      // 1. bypass, one idle cycle mid-packet
      drv_word({2'b01, 4'h0, 64'hB0B0_0000_0000_0000, 64'h1}, {32{32'hA5A5_0001}});
      @(negedge clk);
      drv_word({2'b11, 4'h0, 64'hB0B0_0000_0000_0001, 64'h2}, '0);
      drv_word({2'b11, 4'h0, 64'hB0B0_0000_0000_0002, 64'h3}, '0);
      drv_word({2'b10, 4'h0, 64'hB0B0_0000_0000_0003, 64'h4}, '0);
      drv_word({2'b01, 4'h0, 64'hB0B0_0000_0000_0004, 64'h5}, {32{32'h5A5A_0002}});
      drv_word({2'b10, 4'h0, 64'hB0B0_0000_0000_0005, 64'h6}, '0);
      repeat (3) @(negedge clk);
      chk("byp_gen_cnt", 64'(gen_pkt_cnt), 0);
      chk("byp_sb_empty", 64'(sb.size()), 0);

      // 2/3. three generated packets, drops in the gap, finish mid third packet
      k = cyc;
      push_gen(4, k + 4);
      push_gen(4, k + 26);
      push_gen(4, k + 48);
      pgm_sent_start_flag = 1'b1;
      wait_gen(1, 40, "gen_pkt1");
      for (int i = 0; i < 3; i++) begin
         in_rd_data = mkw(2'b11, 4'h7, i); in_rd_data_wr = 1'b1;
         @(negedge clk);
      end
      in_rd_data_wr = 1'b0;
      wait_gen(2, 60, "gen_pkt2");
      wait_rd1(60, "gen_rd1_p3");
      pgm_sent_finish_flag = 1'b1;
      wait_gen(3, 40, "gen_pkt3");
      no_rd(40, "fin_no_rd");
      chk("fin_gen_cnt", 64'(gen_pkt_cnt), 3);
      chk("drop_cnt", 64'(drop_word_cnt), 3);
      chk("gen_sb_empty", 64'(sb.size()), 0);
      pgm_sent_finish_flag = 1'b0;
      pgm_sent_start_flag  = 1'b0;
      repeat (3) @(negedge clk);

      // 4. backpressure raised mid-packet and held across the gap end
      k = cyc;
      push_gen(4, k + 4);
      pgm_sent_start_flag = 1'b1;
      wait_rd1(20, "bp_rd1_p1");
      in_rd_alf = 1'b1;
      in_rd_phv_alf = 1'b1;
      wait_gen(4, 20, "bp_pkt1");
      chk("alf_pass", 64'(out_rd_alf), 1);
      chk("phv_alf_pass", 64'(out_rd_phv_alf), 1);
      no_rd(30, "bp_no_rd");
      k = cyc;
      push_gen(4, k + 3);
      in_rd_alf = 1'b0;
      in_rd_phv_alf = 1'b0;
      wait_rd1(10, "bp_rd1_p2");
      pgm_sent_finish_flag = 1'b1;
      wait_gen(5, 20, "bp_pkt2");
      no_rd(20, "bp_fin_no_rd");
      chk("bp_sb_empty", 64'(sb.size()), 0);
      pgm_sent_finish_flag = 1'b0;
      pgm_sent_start_flag  = 1'b0;
      repeat (3) @(negedge clk);

      // 5. wrap guard: no tail in 128 words
      mem[0] = {10'h155, mkw(2'b01, 4'h5, 0)};
      for (int i = 1; i < 128; i++) mem[i] = {10'h155, mkw(2'b11, 4'h5, i)};
      k = cyc;
      push_gen(128, k + 4);
      pgm_sent_start_flag = 1'b1;
      wait_rd1(20, "wrap_rd1");
      pgm_sent_finish_flag = 1'b1;
      wait_gen(6, 300, "wrap_pkt");
      no_rd(20, "wrap_no_rd");
      chk("wrap_sb_empty", 64'(sb.size()), 0);
      pgm_sent_finish_flag = 1'b0;
      pgm_sent_start_flag  = 1'b0;
      repeat (3) @(negedge clk);

      // 6. reset while word 2 of a generated packet is on the output
      load_tmpl();
      k = cyc;
      push_gen(3, k + 4);
      pgm_sent_start_flag = 1'b1;
      while (cyc < k + 6) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mrst_data_wr", 64'(out_rd_data_wr), 0);
      chk("mrst_data", 64'(|out_rd_data), 0);
      chk("mrst_valid_wr", 64'({out_rd_valid, out_rd_valid_wr, out_rd_phv_wr}), 0);
      chk("mrst_rd_en", 64'({rd2ram_rd_en, rd2ram_addr}), 0);
      chk("mrst_gen_cnt", 64'(gen_pkt_cnt), 0);
      chk("mrst_drop_cnt", 64'(drop_word_cnt), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      no_rd(40, "post_rst_no_rd");
      chk("post_rst_gen_cnt", 64'(gen_pkt_cnt), 0);
      chk("post_rst_sb_empty", 64'(sb.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/pgm_rd.md
Name: pgm_rd

Overview:
Read/transmit half of the packet generator, downstream of pgm_wr and PGM_RAM. It forwards bypass packets from pgm_wr unchanged. When pgm_wr signals that a template is stored, it reads that template from PGM_RAM and replays it repeatedly toward the next module until pgm_wr signals finish. It then completes the current packet and returns to idle.

Parameters:
PLATFORM, "Xilinx", target vendor tag.
LMID, 8'd63, local module ID.
GAP_CYCLES, 16, idle cycles between generated packets; 0 means back-to-back.
RAM_AW, 7, PGM_RAM address width (128 words max).

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_rd_phv  in  1024  PHV from pgm_wr
in_rd_phv_wr  in  1  PHV strobe
out_rd_phv_alf  out  1  = in_rd_phv_alf (combinational pass-through)
in_rd_data  in  134  data word from pgm_wr; [133:132] 01=head, 11=body, 10=tail
in_rd_data_wr  in  1  data strobe
in_rd_valid  in  1  packet valid
in_rd_valid_wr  in  1  valid strobe
out_rd_alf  out  1  = in_rd_alf (combinational pass-through)
pgm_bypass_flag  in  1  pgm_wr is bypassing
pgm_sent_start_flag  in  1  template stored (level)
pgm_sent_finish_flag  in  1  stop generating (sticky level)
rd2ram_rd_en  out  1  RAM read enable
rd2ram_addr  out  RAM_AW  RAM read address
ram2rd_rdata  in  144  RAM read data, 1-cycle latency; [133:0] is the word
out_rd_phv  out  1024  PHV to next module
out_rd_phv_wr  out  1  PHV strobe
in_rd_phv_alf  in  1  downstream PHV almost-full
out_rd_data  out  134  data to next module
out_rd_data_wr  out  1  data strobe
out_rd_valid  out  1  packet valid
out_rd_valid_wr  out  1  valid strobe
in_rd_alf  in  1  downstream data almost-full
gen_pkt_cnt  out  32  generated packets since reset
drop_word_cnt  out  16  bypass words dropped during generation

Behaviour:
- Reset: all outputs 0, counters 0, state IDLE_S, edge-detect registers 0.
- Edge detect: start_p and finish_p are rising edges of the respective flags, registered one cycle. finish_p sets a sticky stop_req. stop_req clears on entry to IDLE_S.
- States: IDLE_S, BYPASS_S, RD_S, GAP_S.
- IDLE_S:
  - Head word with data_wr → register word, PHV, valid onto outputs (1-cycle latency); go to BYPASS_S.
  - Else if start_p and !in_rd_alf → rd_en=1, addr=0; go to RD_S.
  - Else if start_p and in_rd_alf → hold start pending until in_rd_alf=0.
  - Bypass takes priority over start.
- BYPASS_S:
  - Each word with data_wr is registered straight through; PHV and PHV_wr track the input.
  - Tail → out_rd_valid=1, out_rd_valid_wr=1; return to IDLE_S.
  - Cycles with no data_wr → outputs strobes 0.
- RD_S:
  - rd_en held 1; addr increments each cycle.
  - RAM word from cycle t appears on out_rd_data with out_rd_data_wr=1 at cycle t+2. Net latency start_p → first out word = 3 cycles.
  - Head word: out_rd_phv_wr=1, out_rd_phv=0.
  - On reading a tail word: rd_en=0; registered output carries valid=1, valid_wr=1; gen_pkt_cnt++ (wraps at 2^32).
  - Address reaches 2^RAM_AW−1 with no tail: that word is emitted with [133:132] forced to 10 (wrap guard).
  - After the tail: stop_req → IDLE_S; else if GAP_CYCLES=0 and !in_rd_alf → restart at addr 0; else → GAP_S.
  - in_rd_alf is ignored mid-packet; it is sampled only at packet start.
- GAP_S:
  - Counts GAP_CYCLES.
  - stop_req → IDLE_S immediately.
  - At count end with !in_rd_alf → RD_S, addr 0; with in_rd_alf → stay until it clears.
- Input words with data_wr arriving in RD_S or GAP_S are dropped; drop_word_cnt++ (saturates at 16'hFFFF).
- rst mid-packet: outputs clear immediately; no tail is emitted.

Optional Feature:
PGM_RD_TIMESTAMP_EN.
- Defined: a 64-bit free-running cycle counter (reset 0) replaces bits [63:0] of the second word (index 1) of every generated packet. Bypass packets are unchanged.
- Undefined: generated words are emitted verbatim from RAM.

Decomposition:
- Shared package pgm_pkg:
  - Word-type codes HEAD=2'b01, BODY=2'b11, TAIL=2'b10.
  - State encodings.
  - Word width 134, RAM word width 144.
  - Default RAM_AW.
- One sub-module, pgm_rd_gap_cnt: gap counter with load, enable, and done outputs.

Test Plan:
1. Bypass: head / 2 body / tail with in_rd_data[111:109]=000 → identical 4 words out, each 1 cycle later; valid_wr on tail; gen_pkt_cnt=0.
2. Generate: RAM preloaded with 4 words (tail at addr 3); start flag rises, GAP_CYCLES=16 → first word out 3 cycles later; packets repeat every 4+16+2 cycles; gen_pkt_cnt increments per tail.
3. Finish mid-packet: finish rises while addr=1 → current packet completes with tail, then IDLE_S; no further rd_en.
4. Backpressure: in_rd_alf=1 at gap end → no rd_en until it drops; a packet already in progress completes unaffected.
5. Wrap guard: RAM with no tail in 128 words → 128 words out, last has [133:132]=10, valid_wr=1.
6. Reset: assert rst at word 2 of a generated packet → all outputs 0 next edge, counters 0; after release with start still high, no generation occurs (no new edge).
